// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and LS onto one memory port: LS wins contention, IF is forced in after LS_STREAK_MAX contended LS grants.
// Latency gnt->mem_req 1 cycle, rvalid forwarded combinationally; requests wait (not dropped) while a transaction is in flight.
module mem_port_arbiter #(
  parameter int AW            = 32,
  parameter int LS_STREAK_MAX = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [3:0]    ls_be,
  input  logic [AW-1:0] ls_addr,
  input  logic [31:0]   ls_wdata,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [31:0]   ls_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  typedef struct packed {
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } cmd_t;

  localparam logic [3:0] STREAK_MAX = 4'(LS_STREAK_MAX);

  state_t     state;
  logic       owner_ls;
  logic [3:0] streak;
  cmd_t       cmd;

  logic can_grant;
  logic sel_ls;
  logic sel_if;
  logic in_wait;

  // Grants are gated by reset so a held request cannot leak a pulse while reset is asserted.
  assign can_grant = reset_n && (state == IDLE);
  assign sel_ls    = ls_req && (!if_req || (streak != STREAK_MAX));
  assign sel_if    = if_req && !sel_ls;
  assign ls_gnt    = can_grant && sel_ls;
  assign if_gnt    = can_grant && sel_if;

  assign in_wait   = (state == WAIT);
  assign if_rvalid = in_wait && mem_rvalid && !owner_ls;
  assign ls_rvalid = in_wait && mem_rvalid && owner_ls;
  assign if_rdata  = (in_wait && !owner_ls) ? mem_rdata : 32'h0;
  assign ls_rdata  = (in_wait && owner_ls) ? mem_rdata : 32'h0;

  assign mem_we    = cmd.we;
  assign mem_be    = cmd.be;
  assign mem_addr  = cmd.addr;
  assign mem_wdata = cmd.wdata;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      owner_ls <= 1'b0;
      streak   <= 4'd0;
      cmd      <= '0;
      mem_req  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ls_gnt) begin
            cmd      <= '{we: ls_we, be: ls_be, addr: ls_addr, wdata: ls_wdata};
            owner_ls <= 1'b1;
            // Only contended LS grants count toward forcing IF in.
            if (if_req && (streak != STREAK_MAX))
              streak <= streak + 4'd1;
          end else if (if_gnt) begin
            cmd      <= '{we: 1'b0, be: 4'hF, addr: if_addr, wdata: 32'h0};
            owner_ls <= 1'b0;
            streak   <= 4'd0;
          end
          if (ls_gnt || if_gnt) begin
            mem_req <= 1'b1;
            busy    <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
